// File: rtl/mult_div_ctrl.sv
// -----------------------------------------------------------------------------
// mult_div_ctrl
//
// HI/LO unit controller for a MIPS-style pipeline. It runs multiplies on an
// external multiplier, divides on an internal one-bit-per-cycle restoring
// divider, and services MTHI/MTLO writes. Reads (MFHI/MFLO) only need the
// stall output while an operation is in flight.
//
// Configuration:
//   MDU_DIVIDER_EN  defined   -> iterative divider present (DIV/FIX states used)
//                   undefined -> no divider; DIV/DIVU finish in one cycle with
//                                HI/LO unchanged and div_by_zero raised as an
//                                "unsupported op" flag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op           HI/LO instruction presented this cycle and its opcode
//                       (000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI,
//                        101 MTLO, 11x ignored)
//   rs_val, rt_val      operands (rs = dividend/multiplicand/MTxx source)
//   mf_req              MFHI/MFLO in EX this cycle
//   flush               abort whatever is in flight, no HI/LO update
//   mult_en, mult_op1,
//   mult_op2,
//   mult_unsigned       request to the external multiplier (zero outside MUL)
//   mult_result         64-bit product from the external multiplier
//   hi, lo              architectural HI/LO registers
//   busy                operation in flight (MUL/DIV/FIX)
//   stall               busy and the pipeline wants HI/LO or the unit
//   done, div_by_zero   one-cycle completion pulse and its divide-by-zero flag
// -----------------------------------------------------------------------------
module mult_div_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    input  logic        flush,
    output logic        mult_en,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    output logic        mult_unsigned,
    input  logic [63:0] mult_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] op_a, op_b;     // latched multiplier operands
    logic        op_uns;         // latched unsigned flag for the multiplier
    logic        dbz_q;          // completion being reported is a divide-by-zero

    logic is_mul, is_div, is_mthi, is_mtlo;
    assign is_mul  = start && (op[2:1] == 2'b00);
    assign is_div  = start && (op[2:1] == 2'b01);
    assign is_mthi = start && (op == 3'b100);
    assign is_mtlo = start && (op == 3'b101);

`ifdef MDU_DIVIDER_EN
    logic [31:0] div_rem, div_quo, div_dvs;
    logic [4:0]  div_cnt;
    logic        neg_q, neg_r;
    logic        rs_neg, rt_neg;
    logic [32:0] div_shift, div_diff;
    logic [31:0] fix_quo, fix_rem;

    // Signed ops divide magnitudes; signs are reapplied in FIX.
    assign rs_neg    = ~op[0] & rs_val[31];
    assign rt_neg    = ~op[0] & rt_val[31];
    // Partial remainder shifted left with the next dividend bit pulled in
    // from the top of the quotient register.
    assign div_shift = {div_rem, div_quo[31]};
    assign div_diff  = div_shift - {1'b0, div_dvs};
    // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000,
    // negated and truncated to 32 bits is 0x80000000 again.
    assign fix_quo   = neg_q ? -div_quo : div_quo;
    assign fix_rem   = neg_r ? -div_rem : div_rem;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mul) begin
                        state_nxt = S_MUL;
                    end else if (is_div) begin
`ifdef MDU_DIVIDER_EN
                        state_nxt = (rt_val == '0) ? S_DONE : S_DIV;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end
                S_MUL:  state_nxt = S_DONE;
`ifdef MDU_DIVIDER_EN
                S_DIV:  if (div_cnt == 5'd31) state_nxt = S_FIX;
                S_FIX:  state_nxt = S_DONE;
`endif
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy          = 1'b0;
        mult_en       = 1'b0;
        mult_op1      = '0;
        mult_op2      = '0;
        mult_unsigned = 1'b0;
        done          = 1'b0;
        div_by_zero   = 1'b0;
        case (state)
            S_MUL: begin
                busy          = 1'b1;
                mult_en       = 1'b1;
                mult_op1      = op_a;
                mult_op2      = op_b;
                mult_unsigned = op_uns;
            end
            S_DIV, S_FIX: busy = 1'b1;
            S_DONE: begin
                done        = 1'b1;
                div_by_zero = dbz_q;
            end
            default: ;
        endcase
        stall = busy & (start | mf_req);
    end

    // HI/LO and operand latches. Flush blocks every update, including the
    // MUL/FIX result writes and an MTHI/MTLO presented in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here, including the operand latches, is reset so
        // an abort by rst_n mid-operation leaves no stale state behind.
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_uns <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (is_mul) begin
                        op_a   <= rs_val;
                        op_b   <= rt_val;
                        op_uns <= op[0];
                        dbz_q  <= 1'b0;
                    end else if (is_div) begin
`ifdef MDU_DIVIDER_EN
                        dbz_q  <= (rt_val == '0);
`else
                        dbz_q  <= 1'b1;
`endif
                    end else if (is_mthi) begin
                        hi <= rs_val;
                    end else if (is_mtlo) begin
                        lo <= rs_val;
                    end
                end
                S_MUL: begin
                    hi <= mult_result[63:32];
                    lo <= mult_result[31:0];
                end
`ifdef MDU_DIVIDER_EN
                S_FIX: begin
                    hi <= fix_rem;
                    lo <= fix_quo;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef MDU_DIVIDER_EN
    // Restoring divider: one quotient bit per DIV cycle, 32 cycles total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_rem <= '0;
            div_quo <= '0;
            div_dvs <= '0;
            div_cnt <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (state == S_IDLE && is_div && !flush && rt_val != '0) begin
            div_rem <= '0;
            div_quo <= rs_neg ? -rs_val : rs_val;
            div_dvs <= rt_neg ? -rt_val : rt_val;
            div_cnt <= '0;
            neg_q   <= rs_neg ^ rt_neg;
            neg_r   <= rs_neg;
        end else if (state == S_DIV) begin
            div_cnt <= div_cnt + 5'd1;
            if (!div_diff[32]) begin
                div_rem <= div_diff[31:0];
                div_quo <= {div_quo[30:0], 1'b1};
            end else begin
                div_rem <= div_shift[31:0];
                div_quo <= {div_quo[30:0], 1'b0};
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_div_ctrl.sv
`timescale 1ns/1ps
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mf_req = 1'b0;
    logic        flush = 1'b0;
    logic        mult_en, mult_unsigned;
    logic [31:0] mult_op1, mult_op2;
    logic [63:0] mult_result;
    logic [31:0] hi, lo;
    logic        busy, stall, done, div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mult_div_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req), .flush(flush),
        .mult_en(mult_en), .mult_op1(mult_op1), .mult_op2(mult_op2),
        .mult_unsigned(mult_unsigned), .mult_result(mult_result),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done),
        .div_by_zero(div_by_zero)
    );

    // External multiplier: combinational, obeys the unsigned flag it is given.
    always_comb begin
        if (mult_unsigned)
            mult_result = {32'd0, mult_op1} * {32'd0, mult_op2};
        else
            mult_result = $signed({{32{mult_op1[31]}}, mult_op1}) *
                          $signed({{32{mult_op2[31]}}, mult_op2});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycles from the start cycle to the done pulse (0: no done expected).
    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] b);
        case (o)
            3'b000, 3'b001: return 2;
`ifdef MDU_DIVIDER_EN
            3'b010, 3'b011: return (b == 0) ? 1 : 34;
`else
            3'b010, 3'b011: return 1;
`endif
            default: return 0;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // An accepted operation becomes a countdown to its done cycle; its result
    // is computed up front with plain arithmetic and committed on the edge
    // before done.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0, m_op1 = '0, m_op2 = '0;
    bit          m_uns = 0, m_active = 0, m_dbz = 0, m_is_mul = 0;
    int          m_cd = 0;

    always @(posedge clk or negedge rst_n) begin
        longint sa, sb, q, r;
        logic [63:0] prod;
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_active = 0; m_cd = 0; m_dbz = 0; m_is_mul = 0;
        end else if (flush) begin
            m_active = 0;
        end else if (m_active) begin
            if (m_cd == 0) m_active = 0;
            else begin
                if (m_cd == 1) begin m_hi = p_hi; m_lo = p_lo; end
                m_cd--;
            end
        end else if (start) begin
            case (op)
                3'b000, 3'b001: begin
                    m_active = 1; m_cd = 1; m_dbz = 0; m_is_mul = 1;
                    m_op1 = rs_val; m_op2 = rt_val; m_uns = op[0];
                    if (op[0]) prod = 64'(rs_val) * 64'(rt_val);
                    else       prod = 64'(longint'($signed(rs_val)) * longint'($signed(rt_val)));
                    p_hi = prod[63:32]; p_lo = prod[31:0];
                end
                3'b010, 3'b011: begin
                    m_active = 1; m_is_mul = 0;
`ifdef MDU_DIVIDER_EN
                    if (rt_val == 0) begin m_cd = 0; m_dbz = 1; end
                    else begin
                        m_cd = 33; m_dbz = 0;
                        if (op[0]) begin
                            p_lo = rs_val / rt_val; p_hi = rs_val % rt_val;
                        end else begin
                            sa = longint'($signed(rs_val)); sb = longint'($signed(rt_val));
                            q = sa / sb; r = sa % sb;
                            p_lo = q[31:0]; p_hi = r[31:0];
                        end
                    end
`else
                    m_cd = 0; m_dbz = 1;
`endif
                end
                3'b100: m_hi = rs_val;
                3'b101: m_lo = rs_val;
                default: ;
            endcase
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit e_busy, e_done, e_mul;
        e_busy = m_active && (m_cd > 0);
        e_done = m_active && (m_cd == 0);
        e_mul  = m_active && m_is_mul && (m_cd == 1);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("div_by_zero", div_by_zero, e_done && m_dbz);
        check("stall", stall, e_busy && (start || mf_req));
        check("mult_en", mult_en, e_mul);
        check("mult_op1", mult_op1, e_mul ? m_op1 : 32'd0);
        check("mult_op2", mult_op2, e_mul ? m_op2 : 32'd0);
        if (e_mul) check("mult_unsigned", mult_unsigned, m_uns);
    end

    // ---------------- stimulus helpers ----------------
    // Entered and left at posedge+1. With junk set, random starts and mf_req
    // are driven while the operation is expected to be busy.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit junk, output int lat, output bit dz);
        int exp_l;
        exp_l = exp_latency(o, b);
        lat = 0; dz = 0;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        mf_req = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        start = 1'b0; mf_req = 1'b0;
        if (exp_l == 0) return;
        for (int k = 1; k <= 40; k++) begin
            if (junk && k < exp_l) begin
                start  = 1'($urandom_range(0, 1));
                op     = 3'($urandom_range(0, 7));
                rs_val = $urandom; rt_val = $urandom;
                mf_req = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0; mf_req = 1'b0;
            end
            @(negedge clk);
            if (done) begin lat = k; dz = div_by_zero; break; end
            @(posedge clk); #1;
        end
        start = 1'b0; mf_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Flush fk cycles after the start cycle (fk=0: flush together with start).
    task automatic flush_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int fk);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        if (fk == 0) flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        if (fk > 0) begin
            repeat (fk - 1) begin @(posedge clk); #1; end
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit dz;
        logic [2:0] o;
        logic [31:0] a, b;
        int el;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        @(posedge clk); #1;

        // MULT -2 * 3, MFHI waiting during N+1.
        op = 3'b000; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mf_req = 1'b1;
        @(negedge clk);
        check("mult_stall_n1", stall, 1'b1);
        check("mult_en_n1", mult_en, 1'b1);
        check("mult_op1_n1", mult_op1, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        mf_req = 1'b0;
        @(negedge clk);
        check("mult_done_n2", done, 1'b1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        @(posedge clk); #1;

        // DIV -7 / 2, then DIVU 100 / 7.
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 0, lat, dz);
`ifdef MDU_DIVIDER_EN
        check("div_latency", 64'(lat), 64'd34);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
`else
        check("div_unsup_latency", 64'(lat), 64'd1);
        check("div_unsup_flag", dz, 1'b1);
        check("div_unsup_lo", lo, 32'hFFFF_FFFA);
`endif
        issue(3'b011, 32'd100, 32'd7, 0, lat, dz);
`ifdef MDU_DIVIDER_EN
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
`endif

        // Divide by zero with HI/LO preset.
        issue(3'b100, 32'h11, 32'd0, 0, lat, dz);
        issue(3'b101, 32'h22, 32'd0, 0, lat, dz);
        issue(3'b010, 32'd5, 32'd0, 0, lat, dz);
        check("dbz_latency", 64'(lat), 64'd1);
        check("dbz_flag", dz, 1'b1);
        check("dbz_hi", hi, 32'h11);
        check("dbz_lo", lo, 32'h22);

        // Signed overflow case.
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, dz);
`ifdef MDU_DIVIDER_EN
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
`else
        check("ovf_unsup_hi", hi, 32'h11);
`endif

        // Flush in flight, then MULTU 5*6.
        issue(3'b100, 32'h33, 32'd0, 0, lat, dz);
        issue(3'b101, 32'h44, 32'd0, 0, lat, dz);
`ifdef MDU_DIVIDER_EN
        flush_op(3'b010, 32'd1000, 32'd3, 10);
`else
        flush_op(3'b000, 32'd7, 32'd9, 1);
`endif
        check("flush_busy", busy, 1'b0);
        check("flush_hi", hi, 32'h33);
        check("flush_lo", lo, 32'h44);
        issue(3'b001, 32'd5, 32'd6, 0, lat, dz);
        check("multu_latency", 64'(lat), 64'd2);
        check("multu_lo", lo, 32'd30);
        check("multu_hi", hi, 32'd0);

        // Asynchronous reset mid-operation.
        issue(3'b100, 32'h55, 32'd0, 0, lat, dz);
`ifdef MDU_DIVIDER_EN
        op = 3'b010; rs_val = 32'd50; rt_val = 32'd7;
`else
        op = 3'b000; rs_val = 32'd50; rt_val = 32'd7;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef MDU_DIVIDER_EN
        repeat (4) begin @(posedge clk); #1; end
`endif
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        check("async_rst_busy", busy, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op = 3'b100; rs_val = 32'h0000_ABCD; start = 1'b1;
        @(negedge clk);
        check("mthi_busy_pre", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("mthi_hi", hi, 32'h0000_ABCD);
        check("mthi_busy_post", busy, 1'b0);
        check("mthi_done", done, 1'b0);
        @(posedge clk); #1;

        // Randomized operations checked against the model every cycle.
        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_val();
            b = pick_val();
            el = exp_latency(o, b);
            if (el > 0 && $urandom_range(0, 9) == 0) begin
                flush_op(o, a, b, $urandom_range(0, el - 1));
            end else begin
                issue(o, a, b, 1, lat, dz);
                if (el > 0) check("rand_latency", 64'(lat), 64'(el));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: an HI/LO instruction is presented this cycle.
REQ-004 SHALL have port op, input, 3 bits, with this encoding:
- 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
- 11x reserved, ignored.
REQ-005 SHALL have ports rs_val and rt_val, input, 32 bits each: operands; rs is the dividend/multiplicand, rt the divisor/multiplier, rs the MTHI/MTLO source.
REQ-006 SHALL have port mf_req, input, 1 bit: an MFHI/MFLO is in EX this cycle.
REQ-007 SHALL have port flush, input, 1 bit: abort the operation in flight.
REQ-008 SHALL have ports mult_en (out, 1), mult_op1 (out, 32), mult_op2 (out, 32) and mult_unsigned (out, 1): drive the external multiplier.
REQ-009 SHALL have port mult_result, input, 64 bits: the external multiplier's result.
REQ-010 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.
REQ-011 SHALL have ports busy (out, 1), stall (out, 1), done (out, 1 pulse) and div_by_zero (out, 1 pulse).

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIX and DONE.
REQ-013 SHALL, in IDLE with start=1 and op MULT/MULTU, latch the operands and the unsigned flag (op[0]) and go to MUL.
REQ-014 SHALL, in MUL, assert mult_en=1 with the latched operands, write HI<=mult_result[63:32] and LO<=mult_result[31:0] at the end of the cycle, then go to DONE.
REQ-015 SHALL hold mult_en=0 and mult_op1/mult_op2 at 0 outside MUL.
REQ-016 SHALL, in IDLE with start=1 and op DIV/DIVU, go to DIV, or go directly to DONE with div_by_zero set when rt_val=0.
REQ-017 SHALL, in DIV, perform one restoring shift-subtract step per cycle on operand magnitudes (signed ops) or raw operands (unsigned ops), for exactly 32 cycles, then go to FIX.
REQ-018 SHALL, in FIX, write LO=quotient and HI=remainder, then go to DONE.
REQ-019 SHALL apply signed-divide rules in FIX:
- quotient negated when operand signs differ;
- remainder takes the dividend's sign;
- 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 (32-bit truncation).
REQ-020 SHALL leave HI/LO unchanged on divide by zero.
REQ-021 SHALL, in DONE, pulse done=1 for one cycle (plus div_by_zero=1 if applicable) and return to IDLE.
REQ-022 SHALL give a latency from the start cycle N of: MULT done at N+2; DIV done at N+34; divide-by-zero done at N+1.
REQ-023 SHALL execute MTHI/MTLO in IDLE by writing HI or LO from rs_val at the same edge, with no busy and no done.
REQ-024 SHALL assert busy=1 in MUL, DIV and FIX, and busy=0 in IDLE and DONE.
REQ-025 SHALL drive stall = busy & (start | mf_req); a start while busy SHALL be ignored.
REQ-026 SHALL, on flush=1 in any state, return to IDLE at the next edge with HI/LO unchanged and no done; flush has priority over a same-cycle start and over a FIX/MUL write.
REQ-027 SHALL ignore reserved op codes (no state change).

Reset
REQ-028 SHALL, on rst_n=0, immediately force state IDLE and set hi=0, lo=0, busy=0, done=0, div_by_zero=0, mult_en=0, all latched operands and the divider state to 0, including mid-operation.
REQ-029 SHALL resume normal operation at the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL include the iterative divider and the DIV/FIX states when macro MDU_DIVIDER_EN is defined.
REQ-031 SHALL, when MDU_DIVIDER_EN is undefined, omit the divider logic; DIV/DIVU then go IDLE->DONE in one cycle with HI/LO unchanged and div_by_zero=1 (unsupported-op flag), with all other behaviour identical.

Verification
REQ-032 SHALL verify MULT rs=0xFFFFFFFE, rt=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA, done at N+2, stall while mf_req during N+1.
REQ-033 SHALL verify DIV rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, done at N+34; DIVU 100/7 -> LO=14, HI=2.
REQ-034 SHALL verify DIV rt=0 with HI=0x11, LO=0x22 preset -> done and div_by_zero at N+1, HI/LO unchanged.
REQ-035 SHALL verify DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 SHALL verify flush at DIV cycle 10 -> IDLE next cycle, no done, HI/LO unchanged; a new MULTU 5*6 then gives LO=30.
REQ-037 SHALL verify rst_n low mid-DIV -> hi=lo=0, busy=0 immediately (asynchronously), and MTHI 0xABCD after release gives hi=0xABCD with busy never set.
